// File: rtl/fifo_synchronous_param_if.sv
// fifo_synchronous_param_if: producer/consumer bundle for the sync FIFO.
// master drives data_in/we/re/clr_err; slave (the FIFO) returns data and status.
interface fifo_synchronous_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we;
  logic                  re;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data_in,
    output we,
    output re,
    output clr_err,
    input  data_out,
    input  full,
    input  almost_full,
    input  empty,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  data_in,
    input  we,
    input  re,
    input  clr_err,
    output data_out,
    output full,
    output almost_full,
    output empty,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/fifo_synchronous_param.sv
// fifo_synchronous_param: single-clock FIFO, registered read, count + thresholds.
// Ports: clk, rst (sync, active-high), bus (slave side of the FIFO interface).
module fifo_synchronous_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input logic clk,
  input logic rst,
  fifo_synchronous_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] ZERO   = '0;
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  localparam logic [CW-1:0] AF_N   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_N   = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ovf_q;
  logic                  unf_q;

  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;

  // Flags decode only from the registered count.
  assign full_w  = (cnt_q == FULL_N);
  assign empty_w = (cnt_q == ZERO);

  assign wr_acc = bus.we && !full_w;
  assign rd_acc = bus.re && !empty_w;

  // Storage is not reset; stale words are unreachable after pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= ZERO;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= ZERO;
      dout_q <= '0;
    end else if (rd_acc) begin
      rd_ptr <= rd_ptr + ONE;
      dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= ZERO;
    end else begin
      unique case (1'b1)
        (wr_acc && !rd_acc): cnt_q <= cnt_q + ONE;
        (rd_acc && !wr_acc): cnt_q <= cnt_q - ONE;
        default:             cnt_q <= cnt_q;
      endcase
    end
  end

  // A new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.we && full_w) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end
      if (bus.re && empty_w) begin
        unf_q <= 1'b1;
      end else if (bus.clr_err) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.count        = cnt_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt_q >= AF_N);
  assign bus.almost_empty = (cnt_q <= AE_N);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_synchronous_param.sv
// tb_fifo_synchronous_param: table vectors, corner sequences, random vs queue model.
// Drives the FIFO through its interface and counts comparisons.
module tb_fifo_synchronous_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk;
  logic rst;

  fifo_synchronous_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_synchronous_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AFULL_THRESH(AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_ovf  = 1'b0;
  bit         m_unf  = 1'b0;

  typedef struct {
    logic       r;
    logic       w;
    logic       rd;
    logic       c;
    logic [7:0] d;
    int         e_cnt;
    int         e_dout;
    bit         e_ovf;
    bit         e_unf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, w, rd, c, input logic [7:0] d);
    bit f;
    bit e;
    if (r) begin
      mq.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      if (rd && !e) m_dout = mq.pop_front();
      if (w && !f) mq.push_back(d);
      if (w && f) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (rd && e) m_unf = 1'b1;
      else if (c) m_unf = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, int'(bus.count), n);
    chk({tag, ".dout"}, int'(bus.data_out), int'(m_dout));
    chk({tag, ".full"}, int'(bus.full), int'(n == DEPTH));
    chk({tag, ".empty"}, int'(bus.empty), int'(n == 0));
    chk({tag, ".afull"}, int'(bus.almost_full), int'(n >= AF));
    chk({tag, ".aempty"}, int'(bus.almost_empty), int'(n <= AE));
    chk({tag, ".ovf"}, int'(bus.overflow), int'(m_ovf));
    chk({tag, ".unf"}, int'(bus.underflow), int'(m_unf));
  endtask

  task automatic step(input string tag, input logic r, w, rd, c,
                      input logic [7:0] d);
    rst         = r;
    bus.we      = w;
    bus.re      = rd;
    bus.clr_err = c;
    bus.data_in = d;
    @(posedge clk);
    model(r, w, rd, c, d);
    #1;
    check_model(tag);
  endtask

  function automatic void add(logic r, w, rd, c, logic [7:0] d,
                              int ec, int ed, bit eo, bit eu);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.c = c; v.d = d;
    v.e_cnt = ec; v.e_dout = ed; v.e_ovf = eo; v.e_unf = eu;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    bus.clr_err = 1'b0;
    bus.data_in = '0;

    // Plan items 1-3 as constant vectors.
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 0, 8'(i), i, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'hFF, 8, 8'h00, 1, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 0, 1, 0, 8'h00, 8 - i, i, 1, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h08, 1, 1);
    add(0, 0, 0, 1, 8'h00, 0, 8'h08, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step("tbl", tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].c, tbl[i].d);
      chk("tbl_cnt", int'(bus.count), tbl[i].e_cnt);
      chk("tbl_dout", int'(bus.data_out), tbl[i].e_dout);
      chk("tbl_ovf", int'(bus.overflow), int'(tbl[i].e_ovf));
      chk("tbl_unf", int'(bus.underflow), int'(tbl[i].e_unf));
      chk("tbl_full", int'(bus.full), int'(tbl[i].e_cnt == 8));
      chk("tbl_aempty", int'(bus.almost_empty), int'(tbl[i].e_cnt <= 2));
      chk("tbl_afull", int'(bus.almost_full), int'(tbl[i].e_cnt >= 6));
    end

    // Wrap-around.
    for (int i = 0; i < 5; i++) step("wr5", 0, 1, 0, 0, 8'(8'h10 + i));
    for (int i = 0; i < 5; i++) begin
      step("rd5", 0, 0, 1, 0, 8'h00);
      chk("wrap_pre_dout", int'(bus.data_out), 8'h10 + i);
    end
    for (int i = 0; i < 8; i++) step("wrA", 0, 1, 0, 0, 8'(8'hA0 + i));
    chk("wrap_full", int'(bus.full), 1);
    for (int i = 0; i < 8; i++) begin
      step("rdA", 0, 0, 1, 0, 8'h00);
      chk("wrap_dout", int'(bus.data_out), 8'hA0 + i);
    end
    chk("wrap_empty", int'(bus.empty), 1);

    // Simultaneous read/write at mid, full and empty.
    step("rst5", 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step("fill4", 0, 1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) begin
      step("rw_mid", 0, 1, 1, 0, 8'h55);
      chk("rw_mid_cnt", int'(bus.count), 4);
      chk("rw_mid_dout", int'(bus.data_out), 8'h40 + i);
    end
    for (int i = 0; i < 4; i++) step("fill8", 0, 1, 0, 0, 8'(8'h60 + i));
    chk("rw_pre_full", int'(bus.full), 1);
    step("rw_full", 0, 1, 1, 0, 8'hEE);
    chk("rw_full_cnt", int'(bus.count), 7);
    chk("rw_full_ovf", int'(bus.overflow), 1);
    chk("rw_full_dout", int'(bus.data_out), 8'h43);
    for (int i = 0; i < 7; i++) step("drain", 0, 0, 1, 0, 8'h00);
    chk("rw_pre_empty", int'(bus.empty), 1);
    step("rw_empty", 0, 1, 1, 0, 8'h77);
    chk("rw_empty_cnt", int'(bus.count), 1);
    chk("rw_empty_unf", int'(bus.underflow), 1);
    step("rd77", 0, 0, 1, 0, 8'h00);
    chk("rd77_dout", int'(bus.data_out), 8'h77);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 5; i++) step("fill5", 0, 1, 0, 0, 8'(8'hC0 + i));
    step("rst_we", 1, 1, 0, 0, 8'h99);
    chk("rst_cnt", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_unf", int'(bus.underflow), 0);
    step("wr3c", 0, 1, 0, 0, 8'h3C);
    step("rd3c", 0, 0, 1, 0, 8'h00);
    chk("rst_first_dout", int'(bus.data_out), 8'h3C);

    // Random traffic with phases biased toward filling or draining.
    for (int i = 0; i < 4000; i++) begin
      int  wp;
      logic r;
      logic w;
      logic rd;
      logic c;
      wp = ((i / 150) % 2 == 0) ? 75 : 25;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      c  = ($urandom_range(0, 15) == 0);
      step("rnd", r, w, rd, c, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
